// File: rtl/addr_scale_pkg.sv
// Shared types and widths for the scaled-address pipeline and its reciprocal divider.
package addr_scale_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        CALC  = 2'd1,
        IDLE  = 2'd2
    } cfg_state_t;

    localparam int PIPE_LAT   = 4;
    localparam int DEF_ADDR_W = 64;
    localparam int DEF_SZ_W   = 7;

    // Reciprocal of a record size needs one bit more than an address.
    function automatic int recip_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int step_cnt_w(input int addr_w);
        return $clog2(addr_w + 2);
    endfunction

endpackage

// File: rtl/addr_scaler_pipe_recip_div.sv
// Restoring divider for 2^ADDR_W / divisor, one quotient bit per cycle over ADDR_W+1 cycles.
// Latched on start; quotient is held stable after the last step until the next start.
module recip_div
    import addr_scale_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SZ_W   = DEF_SZ_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SZ_W-1:0]             divisor,
    output logic                        busy,
    output logic                        done,
    output logic [recip_w(ADDR_W)-1:0]  quotient
);

    localparam int CW = step_cnt_w(ADDR_W);
    localparam logic [CW-1:0] STEPS = CW'(ADDR_W + 1);

    logic [CW-1:0]   cnt;
    logic [SZ_W-1:0] dvs;
    logic [SZ_W-1:0] rem;
    logic            dividend_bit;
    logic [SZ_W:0]   shifted;
    logic            fits;

    // The dividend is a single 1 followed by ADDR_W zeros, fed MSB first.
    always_comb begin
        dividend_bit = (cnt == STEPS);
        shifted      = {rem, dividend_bit};
        fits         = (shifted >= {1'b0, dvs});
    end

    assign busy = (cnt != '0);
    assign done = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quotient <= '0;
        end else if (start) begin
            cnt      <= STEPS;
            dvs      <= divisor;
            rem      <= '0;
            quotient <= '0;
        end else if (busy) begin
            cnt      <= cnt - CW'(1);
            quotient <= {quotient[recip_w(ADDR_W)-2:0], fits};
            rem      <= fits ? SZ_W'(shifted - {1'b0, dvs}) : shifted[SZ_W-1:0];
        end
    end

endmodule

// File: rtl/addr_scaler_pipe.sv
// Maps packed-record virtual addresses onto the padded line layout; 4-cycle latency, 1/cycle.
// out_ready low freezes every stage; config is only taken with the pipeline empty.
module addr_scaler_pipe
    import addr_scale_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SZ_W   = DEF_SZ_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [SZ_W-1:0]   cfg_line_size,
    input  logic [SZ_W-1:0]   cfg_sub_size,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_vaddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_scaled,
    output logic [ADDR_W-1:0] out_idx,
    output logic [SZ_W-1:0]   out_off,
    output logic              out_err
);

    cfg_state_t state;
    cfg_state_t state_nxt;

    logic [ADDR_W-1:0]          base_q;
    logic [SZ_W-1:0]            line_q;
    logic [SZ_W-1:0]            sub_q;
    logic [recip_w(ADDR_W)-1:0] recip;

    logic cfg_fire;
    logic cfg_ok;
    logic div_start;
    logic div_busy;
    logic div_done;
    logic adv;
    logic in_fire;
    logic pipe_empty;

    logic              s1_vld;
    logic [ADDR_W-1:0] s1_vaddr;
    logic [ADDR_W-1:0] s1_delta;
    logic              s1_err;

    logic              s2_vld;
    logic [ADDR_W-1:0] s2_vaddr;
    logic [ADDR_W-1:0] s2_delta;
    logic              s2_err;
    logic [ADDR_W-1:0] s2_q0;

    logic              s3_vld;
    logic [ADDR_W-1:0] s3_vaddr;
    logic              s3_err;
    logic [ADDR_W-1:0] s3_q0;
    logic [SZ_W:0]     s3_r0;

    logic [2*ADDR_W-1:0] s1_prod;
    logic                s4_corr;
    logic [ADDR_W-1:0]   s4_idx;
    logic [SZ_W:0]       s4_rem;
    logic [ADDR_W-1:0]   s4_scaled;

    recip_div #(
        .ADDR_W (ADDR_W),
        .SZ_W   (SZ_W)
    ) u_recip_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .divisor  (cfg_sub_size),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (recip)
    );

    assign adv        = !out_valid || out_ready;
    assign pipe_empty = !(s1_vld || s2_vld || s3_vld || out_valid);
    assign cfg_ok     = (cfg_sub_size != '0) && (cfg_sub_size <= cfg_line_size);
    assign in_fire    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNCFG;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        case (state)
            UNCFG: cfg_ready = 1'b1;
            CALC:  cfg_ready = 1'b0;
            IDLE:  cfg_ready = pipe_empty;
            default: cfg_ready = 1'b0;
        endcase

        cfg_fire  = cfg_valid && cfg_ready;
        div_start = cfg_fire && cfg_ok;
        // A config offered alongside an address wins the cycle.
        in_ready  = (state == IDLE) && adv && !cfg_fire;

        if (div_start) begin
            state_nxt = CALC;
        end else begin
            case (state)
                CALC: begin
                    if (div_done) begin
                        state_nxt = IDLE;
                    end else if (!div_busy) begin
                        state_nxt = UNCFG;
                    end
                end
                UNCFG, IDLE: state_nxt = state;
                default:     state_nxt = UNCFG;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            line_q  <= '0;
            sub_q   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_fire && !cfg_ok;
            if (div_start) begin
                base_q <= cfg_base;
                line_q <= cfg_line_size;
                sub_q  <= cfg_sub_size;
            end
        end
    end

    // Reciprocal estimate undershoots the true quotient by at most one.
    assign s1_prod = (2*ADDR_W)'(s1_delta) * (2*ADDR_W)'(recip);

    always_comb begin
        s4_corr   = (s3_r0 >= {1'b0, sub_q});
        s4_idx    = s3_q0 + ADDR_W'(s4_corr);
        s4_rem    = s4_corr ? (s3_r0 - {1'b0, sub_q}) : s3_r0;
        s4_scaled = base_q + s4_idx * ADDR_W'(line_q) + ADDR_W'(s4_rem);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld     <= 1'b0;
            s1_vaddr   <= '0;
            s1_delta   <= '0;
            s1_err     <= 1'b0;
            s2_vld     <= 1'b0;
            s2_vaddr   <= '0;
            s2_delta   <= '0;
            s2_err     <= 1'b0;
            s2_q0      <= '0;
            s3_vld     <= 1'b0;
            s3_vaddr   <= '0;
            s3_err     <= 1'b0;
            s3_q0      <= '0;
            s3_r0      <= '0;
            out_valid  <= 1'b0;
            out_scaled <= '0;
            out_idx    <= '0;
            out_off    <= '0;
            out_err    <= 1'b0;
        end else if (adv) begin
            s1_vld   <= in_fire;
            s1_vaddr <= in_vaddr;
            s1_delta <= in_vaddr - base_q;
            s1_err   <= (in_vaddr < base_q);

            s2_vld   <= s1_vld;
            s2_vaddr <= s1_vaddr;
            s2_delta <= s1_delta;
            s2_err   <= s1_err;
            s2_q0    <= ADDR_W'(s1_prod >> ADDR_W);

            s3_vld   <= s2_vld;
            s3_vaddr <= s2_vaddr;
            s3_err   <= s2_err;
            s3_q0    <= s2_q0;
            s3_r0    <= (SZ_W+1)'(s2_delta - s2_q0 * ADDR_W'(sub_q));

            out_valid <= s3_vld;
            if (s3_err) begin
                out_scaled <= s3_vaddr;
                out_idx    <= '0;
                out_off    <= '0;
                out_err    <= 1'b1;
            end else begin
                out_scaled <= s4_scaled;
                out_idx    <= s4_idx;
                out_off    <= SZ_W'(s4_rem);
                out_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addr_scaler_pipe.sv
// Directed and golden-model checks for addr_scaler_pipe with an in-order output scoreboard.
module tb_addr_scaler_pipe;
    import addr_scale_pkg::*;

    localparam int AW = 64;
    localparam int SW = 7;

    typedef struct packed {
        logic [AW-1:0] scaled;
        logic [AW-1:0] idx;
        logic [SW-1:0] off;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [AW-1:0] cfg_base = '0;
    logic [SW-1:0] cfg_line_size = '0;
    logic [SW-1:0] cfg_sub_size = '0;
    logic          cfg_err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_vaddr = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_scaled;
    logic [AW-1:0] out_idx;
    logic [SW-1:0] out_off;
    logic          out_err;

    always #5 clk = ~clk;

    addr_scaler_pipe #(.ADDR_W(AW), .SZ_W(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_base      (cfg_base),
        .cfg_line_size (cfg_line_size),
        .cfg_sub_size  (cfg_sub_size),
        .cfg_err       (cfg_err),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vaddr      (in_vaddr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_scaled    (out_scaled),
        .out_idx       (out_idx),
        .out_off       (out_off),
        .out_err       (out_err)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_out    = 0;
    exp_t          exp_q[$];
    logic [AW-1:0] cur_base = '0;
    int            cur_line = 0;
    int            cur_sub  = 1;

    task automatic check_eq(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [AW-1:0] s, input logic [AW-1:0] i,
                                input logic [SW-1:0] o, input logic e);
        exp_t r;
        r.scaled = s;
        r.idx    = i;
        r.off    = o;
        r.err    = e;
        return r;
    endfunction

    function automatic exp_t gold(input logic [AW-1:0] b, input logic [AW-1:0] va,
                                  input int line, input int sub);
        exp_t          e;
        logic [AW-1:0] d;
        logic [AW-1:0] q;
        logic [AW-1:0] r;
        if (va < b) begin
            e = mk(va, '0, '0, 1'b1);
        end else begin
            d = va - b;
            q = d / AW'(sub);
            r = d % AW'(sub);
            e = mk(b + q * AW'(line) + r, q, SW'(r), 1'b0);
        end
        return e;
    endfunction

    // Scoreboard: every valid output cycle must match the oldest pending expectation.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", AW'(out_valid), 64'd0);
            end else begin
                check_eq("out_scaled", out_scaled, exp_q[0].scaled);
                check_eq("out_idx", out_idx, exp_q[0].idx);
                check_eq("out_off", AW'(out_off), AW'(exp_q[0].off));
                check_eq("out_err", AW'(out_err), AW'(exp_q[0].err));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] va, input exp_t e);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_vaddr = va;
        forever begin
            #1;
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                break;
            end
            waited++;
            if (waited > 300) begin
                check_eq("in_accept_timeout", AW'(in_ready), 64'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_gold(input logic [AW-1:0] va);
        send(va, gold(cur_base, va, cur_line, cur_sub));
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        #3;
        check_eq("drain", AW'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_cfg(input logic [AW-1:0] b, input int line, input int sub);
        int w = 0;
        @(negedge clk);
        cfg_valid     = 1'b1;
        cfg_base      = b;
        cfg_line_size = SW'(line);
        cfg_sub_size  = SW'(sub);
        #1;
        while (!cfg_ready && w < 500) begin
            @(negedge clk);
            #1;
            w++;
        end
        check_eq("cfg_ready_seen", AW'(cfg_ready), 64'd1);
        @(posedge clk);
        cur_base = b;
        cur_line = line;
        cur_sub  = sub;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        w = 1;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        check_eq("cfg_lat", AW'(w), AW'(AW + 2));
    endtask

    task automatic bad_cfg(input int line, input int sub);
        @(negedge clk);
        cfg_valid     = 1'b1;
        cfg_base      = 64'hDEAD_0000;
        cfg_line_size = SW'(line);
        cfg_sub_size  = SW'(sub);
        #1;
        check_eq("bad_cfg_ready", AW'(cfg_ready), 64'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check_eq("cfg_err_pulse", AW'(cfg_err), 64'd1);
        @(negedge clk);
        #1;
        check_eq("cfg_err_clear", AW'(cfg_err), 64'd0);
        check_eq("bad_cfg_in_ready", AW'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int            w;
        int            n0;
        logic [AW-1:0] d;
        logic [AW-1:0] qq;
        int            subs[6] = '{3, 7, 40, 48, 56, 63};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", AW'(out_valid), 64'd0);
        check_eq("rst_cfg_ready", AW'(cfg_ready), 64'd1);
        check_eq("rst_in_ready", AW'(in_ready), 64'd0);
        check_eq("rst_cfg_err", AW'(cfg_err), 64'd0);
        check_eq("rst_out_scaled", out_scaled, 64'd0);
        check_eq("rst_out_idx", out_idx, 64'd0);
        check_eq("rst_out_err", AW'(out_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("uncfg_in_ready", AW'(in_ready), 64'd0);

        // sub=56, line=64 with first-result latency
        do_cfg(64'h1000, 64, 56);
        send(64'h1070, mk(64'h1080, 64'd2, 7'd0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        w = 1;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check_eq("pipe_lat", AW'(w), AW'(PIPE_LAT));
        send(64'h1077, mk(64'h1087, 64'd2, 7'd7, 1'b0));
        idle_in();
        drain();

        do_cfg(64'h1000, 64, 48);
        send(64'h1064, mk(64'h1084, 64'd2, 7'd4, 1'b0));
        idle_in();
        drain();

        do_cfg(64'h0, 1, 1);
        send(64'hFFFF_FFFF_FFFF_FFFF, mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 1'b0));
        idle_in();
        drain();

        // underflow and record boundaries around base
        do_cfg(64'h1000, 64, 56);
        send(64'h0FFF, mk(64'h0FFF, 64'd0, 7'd0, 1'b1));
        send(64'h1000, mk(64'h1000, 64'd0, 7'd0, 1'b0));
        send(64'h1037, mk(64'h1037, 64'd0, 7'd55, 1'b0));
        send(64'h1038, mk(64'h1040, 64'd1, 7'd0, 1'b0));
        idle_in();
        drain();

        bad_cfg(64, 0);
        bad_cfg(64, 65);
        send(64'h1077, mk(64'h1087, 64'd2, 7'd7, 1'b0));
        idle_in();
        drain();

        // six back-to-back inputs, out_ready low for cycles 5..8
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send_gold(64'h1000 + AW'(i * 37));
                idle_in();
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    out_ready = !(c >= 5 && c <= 8);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check_eq("bp_count", AW'(n_out - n0), 64'd6);

        // a config offered while results are stuck in the pipe must wait for them
        @(negedge clk);
        out_ready = 1'b0;
        send_gold(64'h1100);
        send_gold(64'h1200);
        idle_in();
        n0 = n_out;
        fork
            do_cfg(64'h2000, 64, 40);
            begin
                repeat (4) @(negedge clk);
                #1;
                check_eq("cfg_held", AW'(cfg_ready), 64'd0);
                check_eq("cfg_held_nout", AW'(n_out - n0), 64'd0);
                out_ready = 1'b1;
            end
        join
        check_eq("drained_before_cfg", AW'(n_out - n0), 64'd2);
        send(64'h2000 + 64'd1000, mk(64'h2000 + 64'd1600, 64'd25, 7'd0, 1'b0));
        idle_in();
        drain();

        // config and address together in IDLE with an empty pipe
        @(negedge clk);
        cfg_valid     = 1'b1;
        cfg_base      = 64'h2000;
        cfg_line_size = 7'd64;
        cfg_sub_size  = 7'd40;
        in_valid      = 1'b1;
        in_vaddr      = 64'h2005;
        #1;
        check_eq("in_vs_cfg_in_ready", AW'(in_ready), 64'd0);
        check_eq("in_vs_cfg_cfg_ready", AW'(cfg_ready), 64'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        #1;
        w = 1;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        check_eq("in_vs_cfg_lat", AW'(w), AW'(AW + 2));

        // golden sweep with deltas at and just below record multiples
        for (int k = 0; k < 6; k++) begin
            do_cfg(AW'((k + 1) * 32'h1000), 64, subs[k]);
            for (int j = 0; j < 400; j++) begin
                qq = {$urandom, $urandom} >> 7;
                case (j % 4)
                    0:       d = {$urandom, $urandom};
                    1:       d = qq * AW'(subs[k]) + AW'(subs[k] - 1);
                    2:       d = qq * AW'(subs[k]);
                    default: d = AW'($urandom_range(0, 1000));
                endcase
                send_gold(cur_base + d);
            end
            idle_in();
            drain();
        end

        // reset in the middle of the reciprocal computation
        @(negedge clk);
        cfg_valid     = 1'b1;
        cfg_base      = 64'h1000;
        cfg_line_size = 7'd64;
        cfg_sub_size  = 7'd56;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        check_eq("calc_cfg_ready", AW'(cfg_ready), 64'd0);
        check_eq("calc_in_ready", AW'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_calc_in_ready", AW'(in_ready), 64'd0);
        check_eq("rst_calc_cfg_ready", AW'(cfg_ready), 64'd1);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        #1;
        check_eq("uncfg_hold", AW'(in_ready), 64'd0);

        do_cfg(64'h1000, 64, 56);
        send(64'h1070, mk(64'h1080, 64'd2, 7'd0, 1'b0));
        idle_in();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
